// File: rtl/ps2_receiver_if.sv
// PS/2 line pair plus the decoded byte-history and error outputs of the receiver.
// The keyboard/bench side drives the lines (master); the receiver drives the results (slave).
interface ps2_receiver_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keyboard_out;
    logic        byte_valid;
    logic        parity_err;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output ps2_clk, ps2_data,
        input  keyboard_out, byte_valid, parity_err, frame_err, err_count
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keyboard_out, byte_valid, parity_err, frame_err, err_count
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 keyboard deserialiser: sync + glitch filter + 11-bit frame FSM -> {prev, cur} byte history.
// Latency: ~SYNC_STAGES+FILTER_LEN+1 clk from raw stop-bit fall to byte_valid; no backpressure.
module ps2_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input logic          clk,
    input logic          rst_n,
    ps2_receiver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   filt_clk_q, filt_clk_d;
    logic [FCNT_W-1:0]      filt_cnt_q, filt_cnt_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [15:0]            kb_q, kb_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic sync_clk;
    logic sync_dat;
    logic fall;

    assign sync_clk = clk_sync_q[SYNC_STAGES-1];
    assign sync_dat = dat_sync_q[SYNC_STAGES-1];

    // Filtered clock only follows the synchronised clock once it has disagreed for FILTER_LEN cycles.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (sync_clk != filt_clk_q) begin
            if (filt_cnt_q == FCNT_MAX) begin
                filt_clk_d = sync_clk;
            end else begin
                filt_cnt_d = filt_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign fall = filt_clk_q & ~filt_clk_d;

    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        kb_d         = kb_q;
        byte_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!sync_dat) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d[bit_idx_q] = sync_dat;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    parity_d = sync_dat;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sync_dat) begin
                        frame_err_d = 1'b1;
                    end else if ((^shift_q ^ parity_q) != 1'b1) begin
                        parity_err_d = 1'b1;
                    end else begin
                        kb_d         = {kb_q[7:0], shift_q};
                        byte_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            // Keyboard stalled mid-frame: drop the partial frame.
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if ((parity_err_d || frame_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            kb_q         <= 16'd0;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            kb_q         <= kb_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.keyboard_out = kb_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.parity_err   = parity_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: drives PS/2 frames, scoreboards keyboard_out on each byte_valid.
module tb_ps2_receiver;
    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int H              = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_receiver_if bus ();

    ps2_receiver #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int bv_cnt   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_kb;
    logic [15:0] sb_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                bv_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected keyboard_out=%h required no byte_valid", bus.keyboard_out);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (bus.keyboard_out !== sb_exp) begin
                        n_errors++;
                        $display("FAIL sb_keyboard_out got %h required %h", bus.keyboard_out, sb_exp);
                    end
                end
            end
            if (bus.parity_err) perr_cnt++;
            if (bus.frame_err) ferr_cnt++;
            if (bus.parity_err && bus.frame_err) begin
                n_checks++;
                n_errors++;
                $display("FAIL err_exclusive parity_err=1 frame_err=1 required at most one");
            end
        end
    end

    // Watchdog: the stimulus is fixed-length, so this only trips on a bench bug.
    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop,
                             input int nbits, input bit glitch);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            if (glitch) begin
                repeat (4) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (FILTER_LEN - 2) @(negedge clk);
                bus.ps2_clk = 1'b1;
                repeat (H - 4 - (FILTER_LEN - 2)) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            bus.ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d, input bit glitch);
        exp_kb = {exp_kb[7:0], d};
        exp_q.push_back(exp_kb);
        send_bits(d, ~^d, 1'b1, 11, glitch);
        repeat (H) @(negedge clk);
    endtask

    task automatic send_bad(input logic [7:0] d, input logic par, input logic stop);
        send_bits(d, par, stop, 11, 1'b0);
        repeat (H) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.delete();
        exp_kb = 16'h0000;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        n_checks++;
        if ({bus.keyboard_out, bus.byte_valid, bus.parity_err, bus.frame_err, bus.err_count} !== 27'd0) begin
            n_errors++;
            $display("FAIL %s kb=%h bv=%b pe=%b fe=%b cnt=%0d required all zero", tag,
                     bus.keyboard_out, bus.byte_valid, bus.parity_err, bus.frame_err, bus.err_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_zero("post_reset_idle");
    endtask

    task automatic test_single_byte();
        int bv0, pe0, fe0;
        do_reset();
        bv0 = bv_cnt; pe0 = perr_cnt; fe0 = ferr_cnt;
        send_good(8'h1C, 1'b0);
        n_checks++;
        if (bus.keyboard_out !== 16'h001C) begin
            n_errors++; $display("FAIL single_kb got %h required 001c", bus.keyboard_out);
        end
        n_checks++;
        if ((bv_cnt - bv0) != 1 || (perr_cnt - pe0) != 0 || (ferr_cnt - fe0) != 0) begin
            n_errors++;
            $display("FAIL single_pulses bv=%0d pe=%0d fe=%0d required 1 0 0",
                     bv_cnt - bv0, perr_cnt - pe0, ferr_cnt - fe0);
        end
    endtask

    task automatic test_break_sequence();
        logic [7:0]  bytes [3] = '{8'h1C, 8'hF0, 8'h1C};
        logic [15:0] want  [3] = '{16'h001C, 16'h1CF0, 16'hF01C};
        int bv0;
        do_reset();
        bv0 = bv_cnt;
        for (int i = 0; i < 3; i++) begin
            send_good(bytes[i], 1'b0);
            n_checks++;
            if (bus.keyboard_out !== want[i]) begin
                n_errors++; $display("FAIL break_kb%0d got %h required %h", i, bus.keyboard_out, want[i]);
            end
        end
        n_checks++;
        if ((bv_cnt - bv0) != 3) begin
            n_errors++; $display("FAIL break_bv_count got %0d required 3", bv_cnt - bv0);
        end
    endtask

    task automatic test_parity_error();
        int bv0, pe0, fe0;
        do_reset();
        send_good(8'h32, 1'b0);
        bv0 = bv_cnt; pe0 = perr_cnt; fe0 = ferr_cnt;
        send_bad(8'h1C, 1'b1, 1'b1);
        n_checks++;
        if ((perr_cnt - pe0) != 1 || (ferr_cnt - fe0) != 0 || (bv_cnt - bv0) != 0) begin
            n_errors++;
            $display("FAIL parity_pulses pe=%0d fe=%0d bv=%0d required 1 0 0",
                     perr_cnt - pe0, ferr_cnt - fe0, bv_cnt - bv0);
        end
        n_checks++;
        if (bus.keyboard_out !== 16'h0032) begin
            n_errors++; $display("FAIL parity_kb got %h required 0032", bus.keyboard_out);
        end
        n_checks++;
        if (bus.err_count !== 8'd1) begin
            n_errors++; $display("FAIL parity_err_count got %0d required 1", bus.err_count);
        end
    endtask

    task automatic test_timeout();
        int fe0, bv0;
        do_reset();
        fe0 = ferr_cnt;
        send_bits(8'b101, 1'b0, 1'b1, 4, 1'b0);
        repeat (TIMEOUT_CYCLES - 200) @(negedge clk);
        n_checks++;
        if ((ferr_cnt - fe0) != 0) begin
            n_errors++; $display("FAIL timeout_early frame_err=%0d required 0", ferr_cnt - fe0);
        end
        repeat (210) @(negedge clk);
        n_checks++;
        if ((ferr_cnt - fe0) != 1) begin
            n_errors++; $display("FAIL timeout_frame_err got %0d required 1", ferr_cnt - fe0);
        end
        n_checks++;
        if (bus.err_count !== 8'd1) begin
            n_errors++; $display("FAIL timeout_err_count got %0d required 1", bus.err_count);
        end
        bv0 = bv_cnt;
        send_good(8'h5A, 1'b0);
        n_checks++;
        if (bus.keyboard_out[7:0] !== 8'h5A || (bv_cnt - bv0) != 1) begin
            n_errors++;
            $display("FAIL timeout_recover kb=%h bv=%0d required 5a 1", bus.keyboard_out[7:0], bv_cnt - bv0);
        end
    endtask

    task automatic test_glitch_and_stop();
        int bv0, fe0, pe0;
        do_reset();
        bv0 = bv_cnt; pe0 = perr_cnt; fe0 = ferr_cnt;
        send_good(8'h1C, 1'b1);
        n_checks++;
        if (bus.keyboard_out !== 16'h001C || (bv_cnt - bv0) != 1 || (perr_cnt - pe0) != 0
            || (ferr_cnt - fe0) != 0) begin
            n_errors++;
            $display("FAIL glitch_frame kb=%h bv=%0d pe=%0d fe=%0d required 001c 1 0 0",
                     bus.keyboard_out, bv_cnt - bv0, perr_cnt - pe0, ferr_cnt - fe0);
        end
        bv0 = bv_cnt; fe0 = ferr_cnt; pe0 = perr_cnt;
        send_bad(8'h32, ~^8'h32, 1'b0);
        n_checks++;
        if ((ferr_cnt - fe0) != 1 || (perr_cnt - pe0) != 0 || (bv_cnt - bv0) != 0) begin
            n_errors++;
            $display("FAIL stop_err_pulses fe=%0d pe=%0d bv=%0d required 1 0 0",
                     ferr_cnt - fe0, perr_cnt - pe0, bv_cnt - bv0);
        end
        n_checks++;
        if (bus.keyboard_out !== 16'h001C || bus.err_count !== 8'd1) begin
            n_errors++;
            $display("FAIL stop_err_state kb=%h cnt=%0d required 001c 1", bus.keyboard_out, bus.err_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int pe0, fe0;
        do_reset();
        send_good(8'h33, 1'b0);
        send_bits(8'h77, 1'b0, 1'b1, 5, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("midreset_outputs");
        exp_q.delete();
        exp_kb = 16'h0000;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);
        pe0 = perr_cnt; fe0 = ferr_cnt;
        send_good(8'h45, 1'b0);
        n_checks++;
        if (bus.keyboard_out !== 16'h0045) begin
            n_errors++; $display("FAIL midreset_kb got %h required 0045", bus.keyboard_out);
        end
        n_checks++;
        if ((perr_cnt - pe0) != 0 || (ferr_cnt - fe0) != 0 || bus.err_count !== 8'd0) begin
            n_errors++;
            $display("FAIL midreset_errors pe=%0d fe=%0d cnt=%0d required 0 0 0",
                     perr_cnt - pe0, ferr_cnt - fe0, bus.err_count);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        exp_kb       = 16'h0000;
        test_reset();
        test_single_byte();
        test_break_sequence();
        test_parity_error();
        test_timeout();
        test_glitch_and_stop();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
Front-end stage of the keyboard input path. Deserialises the PS/2 keyboard clock/data lines into bytes and presents a 16-bit history word {previous byte, current byte} on keyboard_out. keyboard_out feeds directly into the keyboard key-mapping stage, which uses byte[15:8]==8'hF0 for break detection and byte[7:0] as the scan code. The block also provides glitch filtering, parity/framing checks and a stalled-frame timeout.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchroniser on ps2_clk and ps2_data; minimum 2.
FILTER_LEN, 8, consecutive equal synchronised ps2_clk samples required before the filtered clock level changes.
TIMEOUT_CYCLES, 20000, clk cycles without an accepted falling edge, mid-frame, before the frame is aborted (200 us at 100 MHz).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
keyboard_out  output  16  {previous good byte, latest good byte}.
byte_valid  output  1  one-cycle pulse; keyboard_out updated this cycle.
parity_err  output  1  one-cycle pulse; frame discarded on odd-parity failure.
frame_err  output  1  one-cycle pulse; frame discarded on bad start bit, bad stop bit, or timeout.
err_count  output  8  saturating count of discarded frames (parity or framing).

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; synchroniser and filter registers preset to 1 (idle bus level); timeout counter 0; shift register 0.
- Sync: each of ps2_clk and ps2_data passes through SYNC_STAGES flops. All logic uses only the synchronised values.
- Filter: filt_clk starts at 1. It takes the synchronised ps2_clk value after that value has differed from filt_clk for FILTER_LEN consecutive cycles. Shorter pulses are ignored.
- Edge: fall is asserted for one cycle when filt_clk changes 1->0. The synchronised ps2_data value in that same cycle is the sampled bit.
- Frame format: 11 bits = start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, on fall:
    - bit=0 -> DATA, bit index=0.
    - bit=1 -> stay in IDLE and pulse frame_err.
  - DATA, on fall: shift the bit into position bit index. After the 8th bit -> PARITY.
  - PARITY, on fall: store the parity bit -> STOP.
  - STOP, on fall: return to IDLE and evaluate the frame:
    - stop=0 -> frame_err pulse.
    - Otherwise, if XOR(D7..D0, parity) != 1 -> parity_err pulse.
    - Otherwise, accept the byte.
- Accept: in the cycle after the stop-bit fall, keyboard_out <= {keyboard_out[7:0], byte} and byte_valid=1.
- Latency from the raw ps2_clk stop-bit fall to byte_valid: SYNC_STAGES+FILTER_LEN+1 cycles, ±1 cycle.
- Discarded frames: keyboard_out unchanged; no byte_valid. Each discard increments err_count, which saturates at 255.
- Error pulses: parity_err and frame_err are mutually exclusive. Each appears in the cycle after the detecting edge, or the cycle after timeout expiry.
- Timeout:
  - The counter runs only in DATA/PARITY/STOP. It clears on every fall and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err.
  - A fall in the same cycle as expiry takes priority: it is processed and the counter clears.
- Reset mid-frame: the partial frame is lost with no error pulse. The next frame starts from IDLE.
- Data changes while filt_clk is high have no effect. Only fall samples data.

Test Plan:
- Single byte: send frame 0x1C with parity 0 and stop 1 from reset -> byte_valid once; keyboard_out=16'h001C; no error pulses.
- Break sequence: send 0x1C, 0xF0 (parity 1), 0x1C -> keyboard_out after each frame = 16'h001C, 16'h1CF0, 16'hF01C; three byte_valid pulses.
- Parity error: send 0x1C with parity 1 after a good 0x32 -> one parity_err pulse; keyboard_out stays 16'h0032; err_count=1.
- Timeout: send start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES+10 -> one frame_err pulse; state IDLE; err_count increments. A following clean 0x5A frame -> keyboard_out[7:0]=8'h5A.
- Glitch and stop error: inject ps2_clk low pulses of FILTER_LEN-2 cycles mid-frame -> no extra bits taken. Then send a frame with stop=0 -> frame_err pulse; keyboard_out unchanged.
- Reset mid-frame: assert rst_n low after 5 bits of a frame, then release and send 0x45 -> all outputs 0 during reset; afterwards keyboard_out=16'h0045 with no error pulse.
